// File: rtl/main_memory_pkg.sv
// Shared types for main_memory: FSM state encoding, latency counter width,
// and the block-index extraction used to map word addresses onto storage rows.
package main_memory_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int CNT_W = 8;

  // Drop the in-block word offset, keep only the bits that index storage.
  function automatic logic [31:0] block_index(input logic [63:0] addr,
                                              input int          ofs,
                                              input int          idx);
    logic [63:0] mask;
    mask = (64'd1 << idx) - 64'd1;
    return 32'((addr >> ofs) & mask);
  endfunction

endpackage

// File: rtl/main_memory_block_array.sv
// Block storage: one row per block, sync write, sync read; 1-cycle read latency.
// Read-during-write to the same row returns the new data; no backpressure.
module mem_block_array #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/main_memory.sv
// Block backing store: one request at a time, mem_hit LATENCY cycles after accept;
// mem_ready low until the requester drops its level. MAIN_MEM_ERR_INJECT_EN adds err_inject/mem_err.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 16,
  parameter int MEM_BLOCKS    = 256,
  parameter int READ_LATENCY  = 10,
  parameter int WRITE_LATENCY = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_wdata,
  input  logic                             mem_read,
  input  logic                             mem_write,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_rdata,
  output logic                             mem_ready,
  output logic                             mem_hit
`ifdef MAIN_MEM_ERR_INJECT_EN
  ,
  input  logic                             err_inject,
  output logic                             mem_err
`endif
);

  localparam int OFS = $clog2(BLOCK_SIZE);
  localparam int IDX = $clog2(MEM_BLOCKS);
  localparam int BW  = BLOCK_SIZE * DATA_WIDTH;
  localparam logic [CNT_W-1:0] RD_M1 = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_M1 = CNT_W'(WRITE_LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat;
  logic [IDX-1:0]   blk_q, blk_d, req_blk, rd_addr;
  logic [BW-1:0]    wdata_q, wdata_d, rdata_q, rdata_d, arr_rdata;
  logic             wr_q, wr_d, err_q, err_d, err_in;
  logic             ready_q, ready_d, hit_q, hit_d, arr_we, req;
`ifdef MAIN_MEM_ERR_INJECT_EN
  logic             merr_q, merr_d;
  assign err_in  = err_inject;
  assign mem_err = merr_q;
`else
  assign err_in  = 1'b0;
`endif

  assign req     = mem_read | mem_write;
  assign req_blk = IDX'(block_index(64'(mem_addr), OFS, IDX));
  // Point the read port at the incoming block while idle so a 1-cycle latency still sees it.
  assign rd_addr = (state_q == IDLE) ? req_blk : blk_q;

  mem_block_array #(.WIDTH(BW), .DEPTH(MEM_BLOCKS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (blk_q),
    .wdata (wdata_q),
    .raddr (rd_addr),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    hit_d   = 1'b0;
    arr_we  = 1'b0;
    lat     = mem_write ? WR_M1 : RD_M1;
`ifdef MAIN_MEM_ERR_INJECT_EN
    merr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ready_q && req) begin
          blk_d   = req_blk;
          wdata_d = mem_wdata;
          wr_d    = mem_write;
          err_d   = err_in;
          cnt_d   = lat;
          state_d = (lat == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = DONE;
      end
      DONE: begin
        hit_d   = 1'b1;
        arr_we  = wr_q && !err_q && !rst;
        rdata_d = err_q ? '1 : (wr_q ? wdata_q : arr_rdata);
`ifdef MAIN_MEM_ERR_INJECT_EN
        merr_d  = err_q;
`endif
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      hit_q   <= 1'b0;
`ifdef MAIN_MEM_ERR_INJECT_EN
      merr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      hit_q   <= hit_d;
`ifdef MAIN_MEM_ERR_INJECT_EN
      merr_q  <= merr_d;
`endif
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = ready_q;
  assign mem_hit   = hit_q;

endmodule
